// File: rtl/uart_loader.sv
// Boot loader fed by a UART receiver: parses SYNC/ADDR/COUNT/DATA/CSUM packets
// and turns the payload into 32-bit memory writes while holding the core in reset.
module uart_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              core_resetn,
    output logic              busy,
    output logic              done,
    output logic              err_csum,
    output logic              err_ovf,
    output logic              err_abort
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_DATA, S_CSUM, S_DRAIN
    } state_t;

    state_t              r_state, w_next;
    logic [1:0]          r_bidx;
    logic [15:0]         r_wcnt;
    logic [7:0]          r_sum;
    logic [31:0]         r_shift;
    logic [ADDR_W-1:0]   r_ptr;
    logic [GAP_W-1:0]    r_gap;
    logic                r_wr_valid;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_err_csum, r_err_ovf, r_err_abort;

    logic                w_abort, w_sync, w_byte, w_word_end, w_wr_fire;
    logic [31:0]         w_word;

    // A break or an expired byte gap cancels the packet from any active state.
    assign w_abort    = (r_state != S_IDLE) &&
                        ((rx_valid && rx_break) || (r_gap == GAP_W'(TIMEOUT_CYCLES)));
    assign w_sync     = (r_state == S_IDLE) && rx_valid && !rx_break && (rx_data == SYNC_BYTE);
    assign w_byte     = (r_state != S_IDLE) && rx_valid && !w_abort;
    assign w_word     = {rx_data, r_shift[31:8]};
    assign w_word_end = w_byte && (r_state == S_DATA) && (r_bidx == 2'd3);
    assign w_wr_fire  = r_wr_valid && mem_wr_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_sync) w_next = S_HDR_ADDR;
            S_HDR_ADDR: if (w_byte && r_bidx == 2'd3) w_next = S_HDR_CNT;
            S_HDR_CNT:  if (w_byte && r_bidx[0])
                            w_next = ({rx_data, r_wcnt[7:0]} != 16'd0) ? S_DATA : S_CSUM;
            S_DATA:     if (w_word_end && r_wcnt == 16'd1) w_next = S_CSUM;
            S_CSUM:     if (w_byte) w_next = S_DRAIN;
            S_DRAIN:    if (!r_wr_valid) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        core_resetn = (r_state == S_IDLE);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DRAIN) && !r_wr_valid && !w_abort &&
                      !r_err_csum && !r_err_ovf && !r_err_abort;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bidx      <= '0;
            r_wcnt      <= '0;
            r_sum       <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_gap       <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_err_csum  <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            if (w_wr_fire) r_wr_valid <= 1'b0;

            if (r_state == S_IDLE || rx_valid)           r_gap <= '0;
            else if (r_gap != GAP_W'(TIMEOUT_CYCLES))    r_gap <= r_gap + GAP_W'(1);

            if (w_sync) begin
                r_err_csum  <= 1'b0;
                r_err_ovf   <= 1'b0;
                r_err_abort <= 1'b0;
                r_sum       <= '0;
                r_bidx      <= '0;
            end
            if (w_abort) r_err_abort <= 1'b1;

            if (w_byte) begin
                case (r_state)
                    S_HDR_ADDR: begin
                        r_sum   <= r_sum + rx_data;
                        r_shift <= w_word;
                        r_bidx  <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) r_ptr <= ADDR_W'(w_word & 32'hFFFF_FFFC);
                    end
                    S_HDR_CNT: begin
                        r_sum <= r_sum + rx_data;
                        if (!r_bidx[0]) begin
                            r_wcnt[7:0] <= rx_data;
                            r_bidx      <= 2'd1;
                        end else begin
                            r_wcnt[15:8] <= rx_data;
                            r_bidx       <= 2'd0;
                        end
                    end
                    S_DATA: begin
                        r_sum   <= r_sum + rx_data;
                        r_shift <= w_word;
                        r_bidx  <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_wcnt <= r_wcnt - 16'd1;
                            // A slot being handshaken this cycle is free for the new word.
                            if (r_wr_valid && !mem_wr_ready) begin
                                r_err_ovf <= 1'b1;
                            end else begin
                                r_wr_valid <= 1'b1;
                                r_wr_data  <= w_word;
                                r_wr_addr  <= r_ptr;
                                r_ptr      <= r_ptr + ADDR_W'(4);
                            end
                        end
                    end
                    S_CSUM: if (rx_data != r_sum) r_err_csum <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign mem_wr_valid = r_wr_valid;
    assign mem_wr_addr  = r_wr_addr;
    assign mem_wr_data  = r_wr_data;
    assign err_csum     = r_err_csum;
    assign err_ovf      = r_err_ovf;
    assign err_abort    = r_err_abort;

endmodule
